// File: rtl/glitch_pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// glitch_pkg
//
// Shared definitions for the glitch pulse generator slice.
//   - gp_state_e     : burst sequencer states
//   - CTR_W_DEFAULT  : default width of the internal down-counters
//   - clamp_to_one() : forces zero-valued cycle parameters up to one cycle
// -----------------------------------------------------------------------------
package glitch_pkg;

  localparam int unsigned CTR_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // disarmed, waiting for arm
    ST_ARMED = 3'd1,  // armed, waiting for a fresh trigger rising edge
    ST_DELAY = 3'd2,  // counting down the programmed trigger-to-pulse delay
    ST_PULSE = 3'd3,  // glitch pulse high phase
    ST_GAP   = 3'd4,  // low phase between consecutive pulses
    ST_DONE  = 3'd5   // burst finished, waiting for arm to drop
  } gp_state_e;

  // A pulse, gap or repeat count of zero has no meaningful hardware
  // interpretation, so those parameters are raised to one at elaboration.
  function automatic int unsigned clamp_to_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage : glitch_pkg

// File: rtl/glitch_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// glitch_pulse_gen_if
//
// Control/status bundle of the glitch pulse generator.
//   arm        : level, 1 = allow one burst, 0 = abort / re-arm
//   trigger_in : trigger level from the upstream glitch trigger (sc_clk domain)
//   glitch_out : registered glitch pulse, active-high
//   busy       : burst in progress (delay, pulse or gap)
//   done       : burst completed
//   led_out    : armed and waiting for a trigger edge
//
// master : the controller side (drives arm/trigger_in, observes status)
// slave  : the pulse generator itself
// -----------------------------------------------------------------------------
interface glitch_pulse_gen_if;

  logic arm;
  logic trigger_in;
  logic glitch_out;
  logic busy;
  logic done;
  logic led_out;

  modport master (
    output arm,
    output trigger_in,
    input  glitch_out,
    input  busy,
    input  done,
    input  led_out
  );

  modport slave (
    input  arm,
    input  trigger_in,
    output glitch_out,
    output busy,
    output done,
    output led_out
  );

endinterface : glitch_pulse_gen_if

// File: rtl/glitch_pulse_gen_rise_detect.sv
// -----------------------------------------------------------------------------
// sc_rise_detect
//
// Single-cycle rising-edge detector for a level already synchronous to sc_clk.
// The previous value is held in a register; rise is high in the cycle where
// the input is 1 and was 0 on the previous edge.
//   sc_clk   : clock
//   sc_reset : asynchronous active-low reset (previous value cleared to 0)
//   d        : level to watch
//   rise     : d & ~previous(d)
// -----------------------------------------------------------------------------
module sc_rise_detect (
  input  logic sc_clk,
  input  logic sc_reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: reset is asynchronous (in the sensitivity list) so the register
  // clears without a running clock.
  always_ff @(posedge sc_clk or negedge sc_reset) begin
    if (!sc_reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  // Because d_q resets to 0, a level that is already high coming out of
  // reset looks like a rise once; the consumer only listens while armed.
  assign rise = d & ~d_q;

endmodule : sc_rise_detect

// File: rtl/glitch_pulse_gen.sv
// -----------------------------------------------------------------------------
// glitch_pulse_gen
//
// Downstream stage of the smartcard glitch trigger. While armed it waits for a
// rising edge of trigger_in, counts DELAY_CYCLES sc_clk cycles and then emits
// REPEAT_COUNT pulses of WIDTH_CYCLES high time separated by GAP_CYCLES low
// time. One burst is produced per arm assertion.
//
// Parameters
//   DELAY_CYCLES : cycles from trigger edge detection to first pulse (0 = min)
//   WIDTH_CYCLES : pulse high time (0 clamped to 1)
//   GAP_CYCLES   : low time between pulses (0 clamped to 1)
//   REPEAT_COUNT : pulses per burst (0 clamped to 1)
//   CTR_W        : width of the down-counter and pulse counter
//
// Ports
//   sc_clk   : master clock (smartcard domain)
//   sc_reset : asynchronous active-low reset
//   bus      : glitch_pulse_gen_if.slave (arm, trigger_in in; glitch_out,
//              busy, done, led_out out)
//
// Timing: all outputs are registered and follow the state register by one
// edge. A trigger edge sampled at edge N gives the first high glitch_out after
// edge N+DELAY_CYCLES+1. An abort (arm low during a burst) clears glitch_out
// and busy on the same edge that returns the sequencer to IDLE.
// -----------------------------------------------------------------------------
module glitch_pulse_gen
  import glitch_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = 0,
  parameter int unsigned WIDTH_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 8,
  parameter int unsigned REPEAT_COUNT = 1,
  parameter int unsigned CTR_W        = CTR_W_DEFAULT
) (
  input  logic               sc_clk,
  input  logic               sc_reset,
  glitch_pulse_gen_if.slave  bus
);

  // Effective (clamped) cycle counts at counter width.
  localparam logic [CTR_W-1:0] DELAY_C  = CTR_W'(DELAY_CYCLES);
  localparam logic [CTR_W-1:0] WIDTH_C  = CTR_W'(clamp_to_one(WIDTH_CYCLES));
  localparam logic [CTR_W-1:0] GAP_C    = CTR_W'(clamp_to_one(GAP_CYCLES));
  localparam logic [CTR_W-1:0] REPEAT_C = CTR_W'(clamp_to_one(REPEAT_COUNT));
  localparam logic [CTR_W-1:0] ONE      = CTR_W'(1);

  gp_state_e        state_q, state_d;
  logic [CTR_W-1:0] ctr_q,   ctr_d;     // cycles left in DELAY/PULSE/GAP
  logic [CTR_W-1:0] cnt_q,   cnt_d;     // pulses completed in this burst
  logic             glitch_d, busy_d, done_d, led_d;
  logic             rise;

  // ---------------------------------------------------------------------------
  // Trigger edge detection: the previous-value register updates in every
  // state, so a level that was already high when ARMED is entered never
  // produces a rise.
  // ---------------------------------------------------------------------------
  sc_rise_detect u_rise (
    .sc_clk   (sc_clk),
    .sc_reset (sc_reset),
    .d        (bus.trigger_in),
    .rise     (rise)
  );

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case statement; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        ctr_d = '0;
        cnt_d = '0;
        if (bus.arm) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        // Abort has priority over a simultaneous trigger edge.
        if (!bus.arm) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          if (DELAY_C == '0) begin
            state_d = ST_PULSE;
            ctr_d   = WIDTH_C;
          end else begin
            state_d = ST_DELAY;
            ctr_d   = DELAY_C;
          end
        end
      end

      ST_DELAY: begin
        if (!bus.arm) begin
          state_d = ST_IDLE;
          ctr_d   = '0;
          cnt_d   = '0;
        end else if (ctr_q <= ONE) begin
          state_d = ST_PULSE;
          ctr_d   = WIDTH_C;
        end else begin
          ctr_d = ctr_q - ONE;
        end
      end

      ST_PULSE: begin
        if (!bus.arm) begin
          state_d = ST_IDLE;
          ctr_d   = '0;
          cnt_d   = '0;
        end else if (ctr_q <= ONE) begin
          // Last high cycle of this pulse.
          cnt_d = cnt_q + ONE;
          if (cnt_d >= REPEAT_C) begin
            state_d = ST_DONE;
            ctr_d   = '0;
          end else begin
            state_d = ST_GAP;
            ctr_d   = GAP_C;
          end
        end else begin
          ctr_d = ctr_q - ONE;
        end
      end

      ST_GAP: begin
        if (!bus.arm) begin
          state_d = ST_IDLE;
          ctr_d   = '0;
          cnt_d   = '0;
        end else if (ctr_q <= ONE) begin
          state_d = ST_PULSE;
          ctr_d   = WIDTH_C;
        end else begin
          ctr_d = ctr_q - ONE;
        end
      end

      ST_DONE: begin
        // Held until arm drops: one burst per arm assertion.
        if (!bus.arm) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ctr_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Outputs are a registered decode of the current state. glitch_out and
    // busy are additionally qualified by arm so an abort drops them on the
    // same edge that sends the sequencer back to IDLE, not one edge later.
    glitch_d = bus.arm && (state_q == ST_PULSE);
    busy_d   = bus.arm && (state_q inside {ST_DELAY, ST_PULSE, ST_GAP});
    done_d   = (state_q == ST_DONE);
    led_d    = (state_q == ST_ARMED);
  end

  // ---------------------------------------------------------------------------
  // State, counters and output registers. The asynchronous reset drops
  // glitch_out immediately, even mid-pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sc_clk or negedge sc_reset) begin
    if (!sc_reset) begin
      state_q        <= ST_IDLE;
      ctr_q          <= '0;
      cnt_q          <= '0;
      bus.glitch_out <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.led_out    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ctr_q          <= ctr_d;
      cnt_q          <= cnt_d;
      bus.glitch_out <= glitch_d;
      bus.busy       <= busy_d;
      bus.done       <= done_d;
      bus.led_out    <= led_d;
    end
  end

endmodule : glitch_pulse_gen
